// File: rtl/sldma_pkg.sv
// Shared constants for the DMA request/status controller: register offsets and
// bit positions in the DMA configuration address space.
package sldma_pkg;

    localparam int unsigned OffEn      = 32'h000;
    localparam int unsigned OffMode    = 32'h004;
    localparam int unsigned OffDone    = 32'h008;
    localparam int unsigned OffErr     = 32'h00C;
    localparam int unsigned OffIrqen   = 32'h010;
    localparam int unsigned OffPend    = 32'h014;
    localparam int unsigned OffCntBase = 32'h100;

    localparam int unsigned IrqenErrBit = 31;
    // Counter window 0x100..0x1FC gives a 6-bit word index.
    localparam int unsigned CntIdxW     = 6;
    localparam logic        ModePulse   = 1'b1;

endpackage

// File: rtl/sldma_req_chan.sv
// One DMA channel: request conditioning (level or captured pulse), pending bit
// and saturating completion counter.
module sldma_req_chan
    import sldma_pkg::*;
#(
    parameter int unsigned CntW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            periph_req_i,
    input  logic            dma_active_i,
    input  logic            dma_done_i,
    input  logic            en_i,
    input  logic            mode_i,
    input  logic            mode_chg_i,
    input  logic            cnt_clr_i,
    output logic            dma_req_o,
    output logic            pend_o,
    output logic [CntW-1:0] cnt_o
);

    logic            req_prev_q;
    logic            pend_q, pend_d;
    logic            dma_req_q, dma_req_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rise;

    always_comb begin
        rise   = periph_req_i & ~req_prev_q;
        pend_d = pend_q;
        // A new edge beats a concurrent DMA_ACTIVE so no request is lost.
        if (!en_i || (mode_i != ModePulse) || mode_chg_i) begin
            pend_d = 1'b0;
        end else if (rise) begin
            pend_d = 1'b1;
        end else if (dma_active_i) begin
            pend_d = 1'b0;
        end

        dma_req_d = (mode_i == ModePulse) ? pend_d : (periph_req_i & en_i);

        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = CntW'(dma_done_i);
        end else if (dma_done_i && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_prev_q <= 1'b0;
            pend_q     <= 1'b0;
            dma_req_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            req_prev_q <= periph_req_i;
            pend_q     <= pend_d;
            dma_req_q  <= dma_req_d;
            cnt_q      <= cnt_d;
        end
    end

    assign dma_req_o = dma_req_q;
    assign pend_o    = pend_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/sldma_req_ctrl.sv
// N-channel DMA request/status controller: APB register file, sticky done/error
// flags and maskable interrupts around per-channel request conditioning.
module sldma_req_ctrl
    import sldma_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 4,
    parameter int unsigned SYS_DATA_W  = 32,
    parameter int unsigned CFG_ADDR_W  = 12,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   PCLKEN,
    input  logic                   PSEL,
    input  logic                   PEN,
    input  logic                   PWRITE,
    input  logic [CFG_ADDR_W-1:0]  PADDR,
    input  logic [SYS_DATA_W-1:0]  PWDATA,
    output logic [SYS_DATA_W-1:0]  PRDATA,
    input  logic [CHANNEL_NUM-1:0] PERIPH_REQ,
    output logic [CHANNEL_NUM-1:0] DMA_REQ,
    input  logic [CHANNEL_NUM-1:0] DMA_ACTIVE,
    input  logic [CHANNEL_NUM-1:0] DMA_DONE,
    input  logic                   DMA_ERR,
    output logic                   DONE_IRQ,
    output logic                   ERR_IRQ
);

    logic [CHANNEL_NUM-1:0] en_q, en_d;
    logic [CHANNEL_NUM-1:0] mode_q, mode_d, mode_chg;
    logic [CHANNEL_NUM-1:0] done_q, done_d;
    logic [CHANNEL_NUM-1:0] irqen_done_q, irqen_done_d;
    logic                   err_q, err_d;
    logic                   irqen_err_q, irqen_err_d;
    logic                   done_irq_q, done_irq_d;
    logic                   err_irq_q, err_irq_d;

    logic [CHANNEL_NUM-1:0] pend;
    logic [CHANNEL_NUM-1:0] cnt_clr;
    logic [CNT_W-1:0]       cnt [CHANNEL_NUM];

    logic [CFG_ADDR_W-1:0] addr_word;
    logic [CntIdxW-1:0]    cnt_idx;
    logic                  wr;
    logic                  sel_en, sel_mode, sel_done, sel_err, sel_irqen, sel_pend, sel_cnt;
    logic                  unused_bits;

    assign wr        = PSEL & PEN & PWRITE & PCLKEN;
    assign addr_word = {PADDR[CFG_ADDR_W-1:2], 2'b00};
    assign cnt_idx   = addr_word[CntIdxW+1:2];

    assign sel_en    = addr_word == CFG_ADDR_W'(OffEn);
    assign sel_mode  = addr_word == CFG_ADDR_W'(OffMode);
    assign sel_done  = addr_word == CFG_ADDR_W'(OffDone);
    assign sel_err   = addr_word == CFG_ADDR_W'(OffErr);
    assign sel_irqen = addr_word == CFG_ADDR_W'(OffIrqen);
    assign sel_pend  = addr_word == CFG_ADDR_W'(OffPend);
    assign sel_cnt   = addr_word[CFG_ADDR_W-1:8] == (CFG_ADDR_W-8)'(OffCntBase >> 8);

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_comb begin
        en_d         = (wr && sel_en) ? PWDATA[CHANNEL_NUM-1:0] : en_q;
        mode_d       = (wr && sel_mode) ? PWDATA[CHANNEL_NUM-1:0] : mode_q;
        mode_chg     = mode_d ^ mode_q;
        irqen_done_d = (wr && sel_irqen) ? PWDATA[CHANNEL_NUM-1:0] : irqen_done_q;
        irqen_err_d  = (wr && sel_irqen) ? PWDATA[IrqenErrBit] : irqen_err_q;

        // Hardware set wins over a concurrent W1C.
        done_d = done_q;
        if (wr && sel_done) begin
            done_d = done_q & ~PWDATA[CHANNEL_NUM-1:0];
        end
        done_d = done_d | DMA_DONE;
        err_d  = (err_q & ~(wr & sel_err & PWDATA[0])) | DMA_ERR;

        done_irq_d = |(done_d & irqen_done_q);
        err_irq_d  = err_d & irqen_err_q;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            en_q         <= '0;
            mode_q       <= '0;
            done_q       <= '0;
            irqen_done_q <= '0;
            err_q        <= 1'b0;
            irqen_err_q  <= 1'b0;
            done_irq_q   <= 1'b0;
            err_irq_q    <= 1'b0;
        end else begin
            en_q         <= en_d;
            mode_q       <= mode_d;
            done_q       <= done_d;
            irqen_done_q <= irqen_done_d;
            err_q        <= err_d;
            irqen_err_q  <= irqen_err_d;
            done_irq_q   <= done_irq_d;
            err_irq_q    <= err_irq_d;
        end
    end

    for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_chan
        assign cnt_clr[ch] = wr & sel_cnt & (cnt_idx == CntIdxW'(ch));

        sldma_req_chan #(
            .CntW(CNT_W)
        ) u_chan (
            .clk_i       (HCLK),
            .rst_ni      (HRESETn),
            .periph_req_i(PERIPH_REQ[ch]),
            .dma_active_i(DMA_ACTIVE[ch]),
            .dma_done_i  (DMA_DONE[ch]),
            .en_i        (en_d[ch]),
            .mode_i      (mode_d[ch]),
            .mode_chg_i  (mode_chg[ch]),
            .cnt_clr_i   (cnt_clr[ch]),
            .dma_req_o   (DMA_REQ[ch]),
            .pend_o      (pend[ch]),
            .cnt_o       (cnt[ch])
        );
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            if (sel_en) begin
                PRDATA[CHANNEL_NUM-1:0] = en_q;
            end else if (sel_mode) begin
                PRDATA[CHANNEL_NUM-1:0] = mode_q;
            end else if (sel_done) begin
                PRDATA[CHANNEL_NUM-1:0] = done_q;
            end else if (sel_err) begin
                PRDATA[0] = err_q;
            end else if (sel_irqen) begin
                PRDATA[CHANNEL_NUM-1:0] = irqen_done_q;
                PRDATA[IrqenErrBit]     = irqen_err_q;
            end else if (sel_pend) begin
                PRDATA[CHANNEL_NUM-1:0] = pend;
            end else if (sel_cnt) begin
                for (int unsigned ch = 0; ch < CHANNEL_NUM; ch++) begin
                    if (cnt_idx == CntIdxW'(ch)) begin
                        PRDATA[CNT_W-1:0] = cnt[ch];
                    end
                end
            end
        end
    end

    assign DONE_IRQ = done_irq_q;
    assign ERR_IRQ  = err_irq_q;

endmodule

// File: tb/tb_sldma_req_ctrl.sv
// Self-checking bench for sldma_req_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared each cycle to a reference model.
module tb_sldma_req_ctrl;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          PCLKEN = 1'b0;
    logic          PSEL = 1'b0;
    logic          PEN = 1'b0;
    logic          PWRITE = 1'b0;
    logic [11:0]   PADDR = '0;
    logic [31:0]   PWDATA = '0;
    logic [31:0]   PRDATA;
    logic [CH-1:0] PERIPH_REQ = '0;
    logic [CH-1:0] DMA_REQ;
    logic [CH-1:0] DMA_ACTIVE = '0;
    logic [CH-1:0] DMA_DONE = '0;
    logic          DMA_ERR = 1'b0;
    logic          DONE_IRQ;
    logic          ERR_IRQ;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit [CH-1:0] m_en, m_mode, m_done, m_pend, m_req, m_prev, m_irqen_done;
    bit          m_err, m_irqen_err, m_done_irq, m_err_irq;
    int          m_cnt [CH];

    sldma_req_ctrl #(
        .CHANNEL_NUM(CH),
        .SYS_DATA_W (32),
        .CFG_ADDR_W (12),
        .CNT_W      (CW)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .PCLKEN    (PCLKEN),
        .PSEL      (PSEL),
        .PEN       (PEN),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PERIPH_REQ(PERIPH_REQ),
        .DMA_REQ   (DMA_REQ),
        .DMA_ACTIVE(DMA_ACTIVE),
        .DMA_DONE  (DMA_DONE),
        .DMA_ERR   (DMA_ERR),
        .DONE_IRQ  (DONE_IRQ),
        .ERR_IRQ   (ERR_IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read();
        int a;
        logic [31:0] r;
        r = '0;
        a = int'({PADDR[11:2], 2'b00});
        if (PSEL) begin
            if (a == 'h000) r = 32'(m_en);
            else if (a == 'h004) r = 32'(m_mode);
            else if (a == 'h008) r = 32'(m_done);
            else if (a == 'h00C) r = 32'(m_err);
            else if (a == 'h010) r = 32'(m_irqen_done) | (32'(m_irqen_err) << 31);
            else if (a == 'h014) r = 32'(m_pend);
            else if (a >= 'h100 && a < 'h200 && (a - 'h100) / 4 < CH) r = 32'(m_cnt[(a - 'h100) / 4]);
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit          wr;
        int          a;
        bit [CH-1:0] en_n, mode_n, chg;
        if (!HRESETn) begin
            m_en = '0; m_mode = '0; m_done = '0; m_pend = '0; m_req = '0; m_prev = '0;
            m_irqen_done = '0; m_err = 0; m_irqen_err = 0; m_done_irq = 0; m_err_irq = 0;
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
            return;
        end
        wr     = PSEL && PEN && PWRITE && PCLKEN;
        a      = int'({PADDR[11:2], 2'b00});
        en_n   = m_en;
        mode_n = m_mode;
        chg    = '0;
        if (wr && a == 'h000) en_n = PWDATA[CH-1:0];
        if (wr && a == 'h004) begin
            chg    = PWDATA[CH-1:0] ^ m_mode;
            mode_n = PWDATA[CH-1:0];
        end
        for (int c = 0; c < CH; c++) begin
            if (!en_n[c] || !mode_n[c] || chg[c]) m_pend[c] = 0;
            else if (PERIPH_REQ[c] && !m_prev[c]) m_pend[c] = 1;
            else if (DMA_ACTIVE[c]) m_pend[c] = 0;
            m_req[c] = mode_n[c] ? m_pend[c] : (PERIPH_REQ[c] && en_n[c]);
            if (wr && a == 'h100 + 4 * c) m_cnt[c] = int'(DMA_DONE[c]);
            else if (DMA_DONE[c] && m_cnt[c] < CMAX) m_cnt[c]++;
        end
        m_prev = PERIPH_REQ;
        if (wr && a == 'h008) m_done = m_done & ~PWDATA[CH-1:0];
        m_done = m_done | DMA_DONE;
        if (wr && a == 'h00C && PWDATA[0]) m_err = 0;
        if (DMA_ERR) m_err = 1;
        m_done_irq = |(m_done & m_irqen_done);
        m_err_irq  = m_err && m_irqen_err;
        if (wr && a == 'h010) begin
            m_irqen_done = PWDATA[CH-1:0];
            m_irqen_err  = PWDATA[31];
        end
        m_en   = en_n;
        m_mode = mode_n;
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            check("dma_req", 32'(DMA_REQ), 32'(m_req));
            check("done_irq", 32'(DONE_IRQ), 32'(m_done_irq));
            check("err_irq", 32'(ERR_IRQ), 32'(m_err_irq));
            check("prdata", PRDATA, model_read());
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
        model_step();
    endtask

    task automatic apb_idle();
        PSEL = 0; PEN = 0; PWRITE = 0; PCLKEN = 0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        PSEL = 1; PEN = 1; PWRITE = 1; PCLKEN = 1; PADDR = a; PWDATA = d;
        tick();
        apb_idle();
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        PSEL = 1; PEN = 1; PWRITE = 0; PCLKEN = 1; PADDR = a;
        #1;
        d = PRDATA;
        check(name, d, exp);
        tick();
        apb_idle();
    endtask

    initial begin
        logic [CH-1:0] prev_req;
        int            rises;
        logic [31:0]   r1, r2, r3;

        tick();
        tick();
        HRESETn = 1;
        chk_en  = 1;

        // Reset state
        check("rst_dma_req", 32'(DMA_REQ), 32'h0);
        check("rst_irqs", {30'h0, DONE_IRQ, ERR_IRQ}, 32'h0);
        rd_chk("rst_en", 12'h000, 0);
        rd_chk("rst_mode", 12'h004, 0);
        rd_chk("rst_done", 12'h008, 0);
        rd_chk("rst_err", 12'h00C, 0);
        rd_chk("rst_irqen", 12'h010, 0);
        rd_chk("rst_pend", 12'h014, 0);
        for (int c = 0; c < CH; c++) rd_chk("rst_cnt", 12'(12'h100 + 4 * c), 0);
        PERIPH_REQ = '1;
        repeat (3) tick();
        check("dis_req_blocked", 32'(DMA_REQ), 32'h0);
        PERIPH_REQ = '0;
        tick();

        // Level mode
        apb_write(12'h000, 32'h1);
        PERIPH_REQ = 4'b0001;
        check("lvl_req_latency", 32'(DMA_REQ), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("lvl_req_on", 32'(DMA_REQ), 32'h1);
        end
        PERIPH_REQ = '0;
        tick();
        check("lvl_req_off", 32'(DMA_REQ), 32'h0);
        apb_write(12'h010, 32'h1);
        DMA_DONE = 4'b0001;
        tick();
        DMA_DONE = '0;
        check("lvl_done_irq", 32'(DONE_IRQ), 32'h1);
        rd_chk("lvl_done", 12'h008, 32'h1);
        rd_chk("lvl_cnt0", 12'h100, 32'h1);
        apb_write(12'h008, 32'h1);
        check("lvl_done_irq_clr", 32'(DONE_IRQ), 32'h0);

        // Pulse mode: three edges collapse into one request
        apb_write(12'h004, 32'h2);
        apb_write(12'h000, 32'h2);
        rises    = 0;
        prev_req = DMA_REQ;
        for (int k = 0; k < 3; k++) begin
            PERIPH_REQ = 4'b0010;
            tick();
            if (DMA_REQ[1] && !prev_req[1]) rises++;
            prev_req   = DMA_REQ;
            PERIPH_REQ = '0;
            tick();
            if (DMA_REQ[1] && !prev_req[1]) rises++;
            prev_req = DMA_REQ;
        end
        check("pls_one_request", 32'(rises), 32'd1);
        rd_chk("pls_pend_set", 12'h014, 32'h2);
        DMA_ACTIVE = 4'b0010;
        tick();
        DMA_ACTIVE = '0;
        check("pls_req_drop", 32'(DMA_REQ), 32'h0);
        rd_chk("pls_pend_clr", 12'h014, 32'h0);
        PERIPH_REQ = 4'b0010;
        DMA_ACTIVE = 4'b0010;
        tick();
        DMA_ACTIVE = '0;
        PERIPH_REQ = '0;
        rd_chk("pls_set_wins", 12'h014, 32'h2);
        apb_write(12'h000, 32'h0);
        check("dis_req_drop", 32'(DMA_REQ), 32'h0);
        rd_chk("dis_pend_clr", 12'h014, 32'h0);

        // Counter saturation and clear-vs-done race
        for (int k = 0; k < 300; k++) begin
            DMA_DONE = 4'b0100;
            tick();
            DMA_DONE = '0;
            tick();
        end
        rd_chk("sat_cnt2", 12'h108, 32'd255);
        DMA_DONE = 4'b0100;
        apb_write(12'h108, 32'h0);
        DMA_DONE = '0;
        rd_chk("clr_race_cnt2", 12'h108, 32'd1);

        // Error flag
        apb_write(12'h010, 32'h8000_0000);
        DMA_ERR = 1;
        tick();
        DMA_ERR = 0;
        check("err_irq_set", 32'(ERR_IRQ), 32'h1);
        rd_chk("err_set", 12'h00C, 32'h1);
        DMA_ERR = 1;
        apb_write(12'h00C, 32'h1);
        DMA_ERR = 0;
        rd_chk("err_set_wins", 12'h00C, 32'h1);
        apb_write(12'h00C, 32'h1);
        rd_chk("err_w1c", 12'h00C, 32'h0);
        check("err_irq_clr", 32'(ERR_IRQ), 32'h0);

        // Reset with a request outstanding
        apb_write(12'h004, 32'h0);
        apb_write(12'h000, 32'h1);
        PERIPH_REQ = 4'b0001;
        tick();
        check("rst_pre_req", 32'(DMA_REQ), 32'h1);
        HRESETn = 0;
        tick();
        check("rst_req_drop", 32'(DMA_REQ), 32'h0);
        HRESETn    = 1;
        PERIPH_REQ = '0;
        rd_chk("rst_en_clr", 12'h000, 32'h0);
        rd_chk("rst_done_clr", 12'h008, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            r1 = $urandom;
            r2 = $urandom;
            r3 = $urandom;
            HRESETn    = ($urandom_range(0, 399) != 0);
            PSEL       = r1[0];
            PEN        = r1[1];
            PWRITE     = r1[2];
            PCLKEN     = r1[3] | r1[4];
            PWDATA     = $urandom;
            case (r1[11:8])
                4'd0:  PADDR = 12'h000;
                4'd1:  PADDR = 12'h004;
                4'd2:  PADDR = 12'h008;
                4'd3:  PADDR = 12'h00C;
                4'd4:  PADDR = 12'h010;
                4'd5:  PADDR = 12'h014;
                4'd6:  PADDR = 12'h018;
                4'd7:  PADDR = 12'h100;
                4'd8:  PADDR = 12'h104;
                4'd9:  PADDR = 12'h108;
                4'd10: PADDR = 12'h10C;
                4'd11: PADDR = 12'h110;
                4'd12: PADDR = 12'h1FC;
                4'd13: PADDR = 12'h900;
                4'd14: PADDR = 12'h200;
                default: PADDR = {r2[11:2], r1[13:12]};
            endcase
            if (r1[11:8] < 4'd13) PADDR[1:0] = r1[13:12];
            PERIPH_REQ = PERIPH_REQ ^ (r2[CH-1:0] & r2[CH+3:4]);
            DMA_ACTIVE = r3[CH-1:0] & r3[CH+3:4];
            DMA_DONE   = r2[CH+11:12] & r2[CH+15:16] & r3[CH+11:12];
            DMA_ERR    = r3[20] & r3[21] & r3[22] & r3[23];
            tick();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sldma_req_ctrl.md
Name: sldma_req_ctrl

Overview:
- Parametrised N-channel DMA request/status controller placed between peripheral request lines and the DMA core (PL230-class: dma_req/dma_active/dma_done/dma_err).
- Adds what the plain DMA wrapper lacks:
  - per-channel enable;
  - level or pulse request mode, with pulse capture;
  - sticky done/error flags, clearable by W1C;
  - saturating per-channel completion counters;
  - maskable interrupts.
- Configured over an APB slave port in the DMA configuration address space.

Parameters:
- CHANNEL_NUM, 4, number of channels (1..31).
- SYS_DATA_W, 32, APB data width (fixed 32; ≥ CHANNEL_NUM+1).
- CFG_ADDR_W, 12, APB address width.
- CNT_W, 8, done-counter width (1..SYS_DATA_W).

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- PCLKEN  in  1  APB clock enable.
- PSEL  in  1  APB select.
- PEN  in  1  APB enable phase.
- PWRITE  in  1  APB direction.
- PADDR  in  CFG_ADDR_W  APB byte address.
- PWDATA  in  SYS_DATA_W  APB write data.
- PRDATA  out  SYS_DATA_W  APB read data.
- PERIPH_REQ  in  CHANNEL_NUM  raw peripheral requests.
- DMA_REQ  out  CHANNEL_NUM  conditioned request to DMA core.
- DMA_ACTIVE  in  CHANNEL_NUM  core servicing channel.
- DMA_DONE  in  CHANNEL_NUM  core done pulse.
- DMA_ERR  in  1  core bus error pulse.
- DONE_IRQ  out  1  any enabled done flag set.
- ERR_IRQ  out  1  error flag set and enabled.

Behaviour:

Reset and timing
- Reset (HRESETn low at a clock edge) clears all registers, pending bits, edge history, counters, DMA_REQ, DONE_IRQ and ERR_IRQ to 0.
- Reset mid-transfer drops DMA_REQ on the next edge; no flags are retained.
- APB write strobe = PSEL & PEN & PWRITE & PCLKEN; takes effect at that edge.
- APB reads: PRDATA is combinational from PADDR when PSEL=1, else 0. Unmapped addresses read 0; writes to them are ignored.

Register map (word offsets; PADDR[1:0] ignored)
- 0x000 EN [CHANNEL_NUM-1:0]: RW channel enable.
- 0x004 MODE [CHANNEL_NUM-1:0]: RW; 0 = level, 1 = pulse.
- 0x008 DONE [CHANNEL_NUM-1:0]: sticky; W1C.
- 0x00C ERR [0]: sticky; W1C.
- 0x010 IRQEN: [CHANNEL_NUM-1:0] done mask; [31] err mask; RW.
- 0x014 PEND [CHANNEL_NUM-1:0]: RO pulse-pending bits.
- 0x100 + 4*ch CNT: RO count; any write clears it. Channels ≥ CHANNEL_NUM read 0.

Per-channel request conditioning (registered; DMA_REQ updates 1 cycle after its cause)
- Level mode: DMA_REQ[ch] <= PERIPH_REQ[ch] & EN[ch].
- Pulse mode:
  - A rising edge of PERIPH_REQ[ch] (vs. the previous-cycle sample) sets PEND[ch] when EN[ch]=1.
  - PEND[ch] clears in the cycle DMA_ACTIVE[ch]=1.
  - If an edge and DMA_ACTIVE coincide, set wins and PEND stays 1, so no request is lost.
  - DMA_REQ[ch] <= PEND_next[ch].
  - Multiple edges while PEND=1 collapse into one request.
- EN[ch] cleared (write): PEND[ch] and DMA_REQ[ch] go to 0 at the next edge.
- Changing MODE: PEND[ch] is cleared.

Status and interrupts
- DMA_DONE[ch]=1 sets DONE[ch] and increments CNT[ch], saturating at 2^CNT_W−1 (no wrap).
- DMA_ERR=1 sets ERR.
- Simultaneous hardware set and W1C clear: set wins.
- Simultaneous DMA_DONE and CNT write: CNT becomes 1.
- DONE_IRQ <= |(DONE_next & IRQEN[CHANNEL_NUM-1:0]).
- ERR_IRQ <= ERR_next & IRQEN[31].
- Both are registered; they assert 1 cycle after the flag sets.

Decomposition:
- Package sldma_pkg: register offset localparams (EN, MODE, DONE, ERR, IRQEN, PEND, CNT_BASE) and the IRQEN err-bit index (31).
- Sub-module sldma_req_chan: one instance per channel via generate. It contains the edge detector, PEND, DMA_REQ register and saturating CNT; ports are the channel slice plus EN/MODE bits and the cnt-clear strobe.
- The top level holds the APB decode, sticky flags and IRQ logic.

Test Plan:
- Reset sequence → all outputs 0; every register reads 0; PERIPH_REQ=all-1 with EN=0 → DMA_REQ stays 0.
- Level mode:
  - EN=0x1; PERIPH_REQ[0] held high 5 cycles → DMA_REQ[0] high cycles 2–6.
  - DMA_DONE[0] pulse → DONE=0x1, CNT0=1; with IRQEN=0x1, DONE_IRQ=1 next cycle.
  - W1C 0x1 → DONE_IRQ drops.
- Pulse mode:
  - MODE=EN=0x2; three PERIPH_REQ[1] edges before DMA_ACTIVE[1] → PEND=0x2, one request only.
  - DMA_ACTIVE[1] → PEND=0.
  - Edge in the same cycle as DMA_ACTIVE → PEND stays 0x2.
- Saturation: CNT_W=8, 300 DMA_DONE[2] pulses → CNT2=255. Write CNT2 concurrent with DMA_DONE → CNT2=1.
- Error: DMA_ERR pulse, IRQEN=0x8000_0000 → ERR=1, ERR_IRQ=1. W1C in the same cycle as a new DMA_ERR → ERR stays 1.
- Disable mid-request: pulse PEND set, then write EN=0 → DMA_REQ=0 and PEND=0 next cycle. HRESETn low while DMA_REQ=1 → DMA_REQ=0 next edge.
